// File: rtl/alu_pkg.sv
// ALU operation codes shared between alu_control and the execute stage.
package alu_pkg;

  typedef logic [4:0] alu_code_t;

  localparam alu_code_t ALU_SLL  = 5'd0;
  localparam alu_code_t ALU_SRL  = 5'd1;
  localparam alu_code_t ALU_SRA  = 5'd2;
  localparam alu_code_t ALU_SLLV = 5'd3;
  localparam alu_code_t ALU_SRLV = 5'd4;
  localparam alu_code_t ALU_SRAV = 5'd5;
  localparam alu_code_t ALU_ADD  = 5'd6;
  localparam alu_code_t ALU_ADDU = 5'd7;
  localparam alu_code_t ALU_SUB  = 5'd8;
  localparam alu_code_t ALU_SUBU = 5'd9;
  localparam alu_code_t ALU_AND  = 5'd10;
  localparam alu_code_t ALU_OR   = 5'd11;
  localparam alu_code_t ALU_XOR  = 5'd12;
  localparam alu_code_t ALU_NOR  = 5'd13;
  localparam alu_code_t ALU_SLT  = 5'd14;
  localparam alu_code_t ALU_SLTU = 5'd15;
  localparam alu_code_t ALU_LUI  = 5'd16;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU datapath: operands, code and shift amount to result and status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_code_t       code,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            ovf,
  output logic            illegal
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [4:0]      vamt;

  assign sum  = a + b;
  assign diff = a - b;
  assign vamt = a[4:0];

  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    unique case (code)
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_SLLV: result = b << vamt;
      ALU_SRLV: result = b >> vamt;
      ALU_SRAV: result = $unsigned($signed(b) >>> vamt);
      ALU_ADD: begin
        result = sum;
        ovf    = (a[XLEN-1] == b[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_ADDU: result = sum;
      ALU_SUB: begin
        result = diff;
        ovf    = (a[XLEN-1] != b[XLEN-1]) & (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUBU: result = diff;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one registered ALU operation per accepted transfer, valid/ready on both sides.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_ctrl,
  input  logic [4:0]       shamt,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic             reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_wen,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  logic [XLEN-1:0] core_result;
  logic            core_ovf;
  logic            core_illegal;
  logic            take;

  assign in_ready = ~flush & (~out_valid | out_ready);
  assign take     = in_valid & in_ready;

  alu_core #(.XLEN(XLEN)) u_core (
    .a       (op_a),
    .b       (op_b),
    .code    (alu_ctrl),
    .shamt   (shamt),
    .result  (core_result),
    .ovf     (core_ovf),
    .illegal (core_illegal)
  );

  // zero is captured alongside result so that it reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      out_wen   <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (take)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      if (take) begin
        result  <= core_result;
        out_tag <= rd_tag;
        out_wen <= reg_write & ~core_ovf & ~core_illegal;
        zero    <= (core_result == '0);
        ovf     <= core_ovf;
        illegal <= core_illegal;
      end
    end
  end

endmodule
